// File: rtl/pulse_sync_pkg.sv
// Shared types for the multi-channel pulse re-timer.
// FSM state encoding and width used by every channel.
package pulse_sync_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/pulse_sync_n_if.sv
// Request/response bundle for pulse_sync_n.
// ovr_cnt and OVR_CW exist only with PULSE_SYNC_OVR_CNT_EN defined.
interface pulse_sync_n_if #(
    parameter int NCH = 4
`ifdef PULSE_SYNC_OVR_CNT_EN
    , parameter int OVR_CW = 8
`endif
);
    logic           slow_en;
    logic [NCH-1:0] pulse_in;
    logic [NCH-1:0] ovr_clr;
    logic [NCH-1:0] pulse_out;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] ovr;
`ifdef PULSE_SYNC_OVR_CNT_EN
    logic [NCH*OVR_CW-1:0] ovr_cnt;

    modport master (
        output slow_en, pulse_in, ovr_clr,
        input  pulse_out, busy, ovr, ovr_cnt
    );
    modport slave (
        input  slow_en, pulse_in, ovr_clr,
        output pulse_out, busy, ovr, ovr_cnt
    );
`else
    modport master (
        output slow_en, pulse_in, ovr_clr,
        input  pulse_out, busy, ovr
    );
    modport slave (
        input  slow_en, pulse_in, ovr_clr,
        output pulse_out, busy, ovr
    );
`endif
endinterface

// File: rtl/pulse_sync_chan.sv
// One channel: IDLE/ARMED/HOLD FSM, hold counter, sticky overrun flag.
// Saturating overrun counter built only with PULSE_SYNC_OVR_CNT_EN.
module pulse_sync_chan
    import pulse_sync_pkg::*;
#(
    parameter int HOLD_TICKS = 1,
    parameter int HOLD_W     = 8
`ifdef PULSE_SYNC_OVR_CNT_EN
    , parameter int OVR_CW   = 8
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slow_en_i,
    input  logic              pulse_i,
    input  logic              ovr_clr_i,
    output logic              pulse_o,
    output logic              busy_o,
`ifdef PULSE_SYNC_OVR_CNT_EN
    output logic [OVR_CW-1:0] ovr_cnt_o,
`endif
    output logic              ovr_o
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              pulse_q, busy_q;
    logic              ovr_q, ovr_d;
    logic              ovr_ev;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A request is never queued: any pulse while busy is an overrun.
        ovr_ev  = pulse_i && (state_q != S_IDLE);
        ovr_d   = ovr_ev | (ovr_q & ~ovr_clr_i);
        case (state_q)
            S_IDLE: begin
                if (pulse_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (slow_en_i) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (slow_en_i) begin
                    if (cnt_q == '0) state_d = S_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == S_HOLD);
            busy_q  <= (state_d != S_IDLE);
            ovr_q   <= ovr_d;
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;
    assign ovr_o   = ovr_q;

`ifdef PULSE_SYNC_OVR_CNT_EN
    logic [OVR_CW-1:0] ocnt_q, ocnt_d;

    // Clear and overrun together leave a count of exactly one.
    always_comb begin
        ocnt_d = ocnt_q;
        if (ovr_clr_i)
            ocnt_d = OVR_CW'(ovr_ev);
        else if (ovr_ev && (ocnt_q != '1))
            ocnt_d = ocnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ocnt_q <= '0;
        else       ocnt_q <= ocnt_d;
    end

    assign ovr_cnt_o = ocnt_q;
`endif

endmodule

// File: rtl/pulse_sync_n.sv
// NCH independent fast-to-slow pulse re-timers with overrun flags.
// Define PULSE_SYNC_OVR_CNT_EN to add per-channel overrun counters.
module pulse_sync_n
    import pulse_sync_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int HOLD_TICKS = 1,
    parameter int HOLD_W     = 8,
    parameter int OVR_CW     = 8
) (
    input  logic          fast_clk,
    input  logic          clr,
    pulse_sync_n_if.slave bus
);

    logic [NCH-1:0] pulse_w, busy_w, ovr_w;
`ifdef PULSE_SYNC_OVR_CNT_EN
    logic [NCH*OVR_CW-1:0] ovr_cnt_w;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_sync_chan #(
            .HOLD_TICKS (HOLD_TICKS),
`ifdef PULSE_SYNC_OVR_CNT_EN
            .OVR_CW     (OVR_CW),
`endif
            .HOLD_W     (HOLD_W)
        ) u_chan (
            .clk_i     (fast_clk),
            .rst_i     (clr),
            .slow_en_i (bus.slow_en),
            .pulse_i   (bus.pulse_in[i]),
            .ovr_clr_i (bus.ovr_clr[i]),
            .pulse_o   (pulse_w[i]),
            .busy_o    (busy_w[i]),
`ifdef PULSE_SYNC_OVR_CNT_EN
            .ovr_cnt_o (ovr_cnt_w[i*OVR_CW +: OVR_CW]),
`endif
            .ovr_o     (ovr_w[i])
        );
    end

    assign bus.pulse_out = pulse_w;
    assign bus.busy      = busy_w;
    assign bus.ovr       = ovr_w;

`ifdef PULSE_SYNC_OVR_CNT_EN
    assign bus.ovr_cnt = ovr_cnt_w;
`else
    // Counter width is meaningless without the counters.
    if (OVR_CW < 1) begin : g_ovr_cw_unused
    end
`endif

endmodule

// File: tb/tb_pulse_sync_n.sv
// Bench for pulse_sync_n: directed prefix plus random traffic, checked
// every cycle against a timestamp model of request/slow-tick/hold timing.
module tb_pulse_sync_n;

    localparam int NCH    = 4;
    localparam int OVR_CW = 2;
    localparam int N      = 3000;
    localparam int CMAX   = (1 << OVR_CW) - 1;

    logic clk = 1'b0;
    logic clr;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur = 0;
    bit   run = 0;

    always #5 clk = ~clk;

`ifdef PULSE_SYNC_OVR_CNT_EN
    pulse_sync_n_if #(.NCH(NCH), .OVR_CW(OVR_CW)) ifa ();
    pulse_sync_n_if #(.NCH(NCH), .OVR_CW(OVR_CW)) ifb ();
`else
    pulse_sync_n_if #(.NCH(NCH)) ifa ();
    pulse_sync_n_if #(.NCH(NCH)) ifb ();
`endif

    pulse_sync_n #(
        .NCH(NCH), .HOLD_TICKS(3), .HOLD_W(8), .OVR_CW(OVR_CW)
    ) dut_a (
        .fast_clk(clk), .clr(clr), .bus(ifa.slave)
    );

    pulse_sync_n #(
        .NCH(NCH), .HOLD_TICKS(1), .HOLD_W(8), .OVR_CW(OVR_CW)
    ) dut_b (
        .fast_clk(clk), .clr(clr), .bus(ifb.slave)
    );

    // Stimulus: index 0 is dut_a, index 1 is dut_b (slow_en tied high).
    bit             se [2][N];
    logic [NCH-1:0] pin [N];
    logic [NCH-1:0] ocl [N];
    bit             clr_s [N];

    // Expected outputs visible during cycle n (after edge n-1).
    logic [NCH-1:0] e_out  [2][N+1];
    logic [NCH-1:0] e_busy [2][N+1];
    logic [NCH-1:0] e_ovr  [2][N+1];
    int             e_cnt  [2][NCH][N+1];

    function automatic int next_se(int d, int x);
        for (int m = x + 1; m < N; m++)
            if (se[d][m]) return m;
        return N + 100;
    endfunction

    // A request accepted at t rises after the first slow tick s1 > t and
    // stays up through the HOLD-th tick after s1 (sk); busy spans (t, sk].
    task automatic model(input int d, input int hold);
        int t, s1, sk, cnt;
        bit job, ov, bnow, ev, p, c;
        for (int ch = 0; ch < NCH; ch++) begin
            job = 0; ov = 0; cnt = 0; t = 0; s1 = 0; sk = 0;
            e_out[d][0][ch]  = 1'b0;
            e_busy[d][0][ch] = 1'b0;
            e_ovr[d][0][ch]  = 1'b0;
            e_cnt[d][ch][0]  = 0;
            for (int n = 0; n < N; n++) begin
                p = pin[n][ch];
                c = ocl[n][ch];
                if (clr_s[n]) begin
                    job = 0; ov = 0; cnt = 0;
                    e_out[d][n+1][ch]  = 1'b0;
                    e_busy[d][n+1][ch] = 1'b0;
                end else begin
                    bnow = job && (n > t) && (n <= sk);
                    ev   = p && bnow;
                    if (p && !bnow) begin
                        job = 1; t = n;
                        s1 = next_se(d, n);
                        sk = s1;
                        for (int k = 0; k < hold; k++) sk = next_se(d, sk);
                    end
                    e_busy[d][n+1][ch] = job && (n >= t) && (n < sk);
                    e_out[d][n+1][ch]  = job && (n >= s1) && (n < sk);
                    ov = ev ? 1'b1 : (c ? 1'b0 : ov);
                    if (c) cnt = ev ? 1 : 0;
                    else if (ev && cnt < CMAX) cnt++;
                end
                e_ovr[d][n+1][ch] = ov;
                e_cnt[d][ch][n+1] = cnt;
            end
        end
    endtask

    task automatic check(string name, int cyc, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [NCH*OVR_CW-1:0] ev;
        if (run && cur >= 1 && cur <= N) begin
            check("a_pulse_out", cur, 32'(ifa.pulse_out), 32'(e_out[0][cur]));
            check("a_busy", cur, 32'(ifa.busy), 32'(e_busy[0][cur]));
            check("a_ovr", cur, 32'(ifa.ovr), 32'(e_ovr[0][cur]));
            check("b_pulse_out", cur, 32'(ifb.pulse_out), 32'(e_out[1][cur]));
            check("b_busy", cur, 32'(ifb.busy), 32'(e_busy[1][cur]));
            check("b_ovr", cur, 32'(ifb.ovr), 32'(e_ovr[1][cur]));
`ifdef PULSE_SYNC_OVR_CNT_EN
            for (int ch = 0; ch < NCH; ch++)
                ev[ch*OVR_CW +: OVR_CW] = OVR_CW'(e_cnt[0][ch][cur]);
            check("a_ovr_cnt", cur, 32'(ifa.ovr_cnt), 32'(ev));
            for (int ch = 0; ch < NCH; ch++)
                ev[ch*OVR_CW +: OVR_CW] = OVR_CW'(e_cnt[1][ch][cur]);
            check("b_ovr_cnt", cur, 32'(ifb.ovr_cnt), 32'(ev));
`else
            ev = '0;
`endif
        end
    end

    initial begin
        int mode;
        for (int n = 0; n < N; n++) begin
            se[0][n] = ((n % 4) == 3);
            se[1][n] = 1'b1;
            pin[n] = '0;
            ocl[n] = '0;
            clr_s[n] = (n < 2);
        end
        pin[4]  = 4'b0001;
        pin[30] = 4'b0100;
        pin[33] = 4'b0100;
        ocl[36] = 4'b0100;
        pin[38] = 4'b0100;
        pin[42] = 4'b0100;
        ocl[42] = 4'b0100;
        pin[50] = 4'b1001;
        pin[53] = 4'b0010;
        pin[70] = 4'b0001;
        pin[74] = 4'b0001;
        clr_s[79] = 1'b1;
        pin[82] = 4'b0001;
        for (int n = 90; n <= 96; n++)
            if (n != 91) pin[n] = 4'b0010;
        ocl[98]  = 4'b0010;
        pin[100] = 4'b0010;
        ocl[100] = 4'b0010;
        mode = 0;
        for (int n = 110; n < N; n++) begin
            if ((n % 200) == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       se[0][n] = ($urandom_range(0, 3) == 0);
                1:       se[0][n] = 1'b1;
                default: se[0][n] = ((n % 3) == 0);
            endcase
            for (int ch = 0; ch < NCH; ch++) begin
                pin[n][ch] = ($urandom_range(0, 7) == 0);
                ocl[n][ch] = ($urandom_range(0, 15) == 0);
            end
            clr_s[n] = ($urandom_range(0, 299) == 0);
        end

        model(0, 3);
        model(1, 1);

        check("pin_a_busy_on", 5, 32'(e_busy[0][5][0]), 1);
        check("pin_a_out_pre", 7, 32'(e_out[0][7][0]), 0);
        check("pin_a_out_rise", 8, 32'(e_out[0][8][0]), 1);
        check("pin_a_out_last", 19, 32'(e_out[0][19][0]), 1);
        check("pin_a_out_fall", 20, 32'(e_out[0][20][0]), 0);
        check("pin_b_out", 6, 32'(e_out[1][6][0]), 1);
        check("pin_b_out_off", 7, 32'(e_out[1][7][0]), 0);
        check("pin_b_busy_off", 7, 32'(e_busy[1][7][0]), 0);
        check("pin_ovr_pre", 33, 32'(e_ovr[0][33][2]), 0);
        check("pin_ovr_set", 34, 32'(e_ovr[0][34][2]), 1);
        check("pin_ovr_clr", 37, 32'(e_ovr[0][37][2]), 0);
        check("pin_ovr_set2", 39, 32'(e_ovr[0][39][2]), 1);
        check("pin_ovr_setwins", 43, 32'(e_ovr[0][43][2]), 1);
        check("pin_ch1_pre", 55, 32'(e_out[0][55][1]), 0);
        check("pin_ch1_rise", 56, 32'(e_out[0][56][1]), 1);
        check("pin_ch1_fall", 68, 32'(e_out[0][68][1]), 0);
        check("pin_ch2_idle", 60, 32'(e_out[0][60][2]), 0);
        check("pin_midhold_on", 79, 32'(e_out[0][79][0]), 1);
        check("pin_rst_out", 80, 32'(e_out[0][80]), 0);
        check("pin_rst_busy", 80, 32'(e_busy[0][80]), 0);
        check("pin_rst_ovr", 80, 32'(e_ovr[0][80]), 0);
        check("pin_after_rst", 84, 32'(e_out[0][84][0]), 1);
`ifdef PULSE_SYNC_OVR_CNT_EN
        check("pin_cnt_sat", 97, 32'(e_cnt[0][1][97]), 3);
        check("pin_cnt_clr", 99, 32'(e_cnt[0][1][99]), 0);
        check("pin_cnt_one", 101, 32'(e_cnt[0][1][101]), 1);
`endif

        run = 1;
        for (int n = 0; n < N; n++) begin
            cur = n;
            clr = clr_s[n];
            ifa.slow_en  = se[0][n];
            ifa.pulse_in = pin[n];
            ifa.ovr_clr  = ocl[n];
            ifb.slow_en  = se[1][n];
            ifb.pulse_in = pin[n];
            ifb.ovr_clr  = ocl[n];
            @(posedge clk);
            #1;
        end
        cur = N;
        @(negedge clk);
        #1;
        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_sync_n.md
Name: pulse_sync_n

Overview:
- Multi-channel successor to the single-pulse reset synchronizer.
- Captures one-cycle pulses on fast_clk. Re-times each pulse to the slow timebase, marked by the slow_en strobe (one fast_clk cycle per slow-clock edge). Holds each output for a programmable number of slow ticks.
- Sits between fast-domain control logic and slow-domain consumers (resets, start strobes).
- Flags pulses that arrive while a channel is busy.

Parameters:
- NCH, 4, number of independent channels (>=1).
- HOLD_TICKS, 1, slow ticks each output stays high (1..2^HOLD_W).
- HOLD_W, 8, width of per-channel hold counter.
- OVR_CW, 8, width of per-channel overrun counter (optional feature only).

Ports:
- fast_clk  in  1  sole clock.
- clr  in  1  synchronous active-high reset.
- slow_en  in  1  one-cycle strobe marking each slow-clock edge.
- pulse_in  in  NCH  per-channel request pulses; any high cycle is a request.
- ovr_clr  in  NCH  per-channel clear of sticky overrun flag.
- pulse_out  out  NCH  stretched, slow-aligned output pulses.
- busy  out  NCH  channel not in IDLE.
- ovr  out  NCH  sticky overrun flags.
- ovr_cnt  out  NCH*OVR_CW  saturating overrun counts, channel i at [i*OVR_CW +: OVR_CW]; present only with the macro defined.

Behaviour:
- Channels are fully independent; each channel runs one FSM: IDLE, ARMED, HOLD. Encoding: IDLE=2'b00, ARMED=2'b01, HOLD=2'b10.
- Reset (clr high at a fast_clk edge):
  - all FSMs -> IDLE;
  - pulse_out=0, busy=0, ovr=0, hold counters=0, ovr_cnt=0.
  - clr overrides all other inputs. Reset mid-HOLD drops pulse_out on the next cycle, with no completion of the hold.
- IDLE:
  - pulse_in[i]=1 -> ARMED next cycle. This holds even if slow_en is high in the same cycle: no direct IDLE->HOLD transition.
- ARMED:
  - waits for slow_en. On slow_en=1 -> HOLD, counter loaded with HOLD_TICKS-1, pulse_out[i]=1 from the next cycle.
  - Latency, pulse_in to pulse_out: 2 fast cycles minimum (slow_en in the cycle after the pulse). Otherwise 1 cycle after the first slow_en that follows ARMED entry.
- HOLD:
  - pulse_out[i]=1.
  - On slow_en with counter!=0: decrement.
  - On slow_en with counter==0: -> IDLE, pulse_out[i]=0 next cycle.
  - Output is therefore high for exactly HOLD_TICKS slow periods, and both edges are registered one cycle after a slow_en.
- pulse_out and busy are registered outputs. busy=1 in ARMED and HOLD.
- Overrun:
  - pulse_in[i]=1 while the channel is in ARMED or HOLD is not queued. It sets ovr[i] next cycle.
  - This includes the final HOLD cycle, where slow_en=1 and counter==0.
- ovr_clr:
  - ovr_clr[i]=1 clears ovr[i] next cycle.
  - Simultaneous ovr_clr and new overrun: set wins.
- slow_en held high continuously is legal; it behaves as slow clock = fast clock.

Optional Feature:
- Macro: PULSE_SYNC_OVR_CNT_EN.
- Defined:
  - ovr_cnt port exists.
  - Each overrun event increments the channel count, saturating at 2^OVR_CW-1.
  - ovr_clr[i] zeroes the count. Simultaneous clear and overrun -> count=1.
- Undefined:
  - port and counters are absent.
  - ovr flags behave identically.

Decomposition:
- Package pulse_sync_pkg: FSM state encodings (IDLE, ARMED, HOLD), state width constant.
- Sub-module pulse_sync_chan: one channel's FSM, hold counter, ovr flag and optional counter.
- Top module instantiates NCH copies in a generate loop and packs the vectors.

Test Plan:
- Reset and single pulse, NCH=4, HOLD_TICKS=3, slow_en every 4th cycle:
  - clr for 2 cycles -> all outputs 0.
  - pulse_in=4'b0001 for 1 cycle -> busy[0]=1 next cycle.
  - pulse_out[0] rises 1 cycle after the next slow_en and stays high 12 cycles.
- Back-to-back slow_en (slow_en tied 1), HOLD_TICKS=1:
  - pulse at cycle 0 -> ARMED at 1, pulse_out high at 2 only, busy low at 3.
- Overrun:
  - pulse ch2 at cycle 0, again at cycle 3 while ARMED/HOLD -> ovr[2]=1 at cycle 4, only one output pulse.
  - ovr_clr[2] -> ovr[2]=0 next cycle.
  - ovr_clr and overrun in the same cycle -> ovr[2] stays 1.
- Channel independence:
  - pulses ch0 and ch3 in the same cycle, ch1 three cycles later -> ch0/ch3 outputs identical.
  - ch1 aligns to its own first slow_en.
  - ch2 stays 0.
- Reset mid-HOLD:
  - clr at 2nd hold tick -> pulse_out, busy, ovr all 0 next cycle.
  - a new pulse after reset is accepted normally.
- With PULSE_SYNC_OVR_CNT_EN, OVR_CW=2:
  - 5 overruns on ch1 -> ovr_cnt[1]=3 (saturated).
  - ovr_clr[1] -> 0.
  - clear plus overrun in the same cycle -> 1.
